// File: rtl/fifo_ptr_pkg.sv
// Shared constants and Gray-code helpers for the read and write pointer blocks of the dual-clock FIFO.
package fifo_ptr_pkg;

  localparam int FIFO_ADDRSIZE = 5;

  typedef logic [FIFO_ADDRSIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = '0;
    for (int i = 0; i <= FIFO_ADDRSIZE; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/rptr_empty_gray2bin.sv
// Combinational Gray-to-binary decoder, used to turn the synchronized write pointer into a count.
module gray2bin #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer, empty flag and sticky underflow of the dual-clock FIFO, clocked on falling rclk.
// Fill level and almost-empty are built only when RPTR_EMPTY_LEVEL_EN is defined.
module rptr_empty
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE      = FIFO_ADDRSIZE,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rempty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rundflow,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                raempty
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic              rd_ok;

  assign rd_ok     = rinc & ~rempty;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];

`ifdef RPTR_EMPTY_LEVEL_EN
  logic [ADDRSIZE:0] rwbin;
  logic [ADDRSIZE:0] level_next;

  gray2bin #(.WIDTH(ADDRSIZE + 1)) u_wptr_dec (
    .gray (rq2_wptr),
    .bin  (rwbin)
  );

  // Modular difference stays correct across pointer wrap.
  assign level_next = rwbin - rbinnext;
`else
  assign rlevel  = '0;
  assign raempty = 1'b1;
`endif

  always_ff @(negedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      rundflow <= 1'b0;
`ifdef RPTR_EMPTY_LEVEL_EN
      rlevel   <= '0;
      raempty  <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking so every flop here samples the pre-edge value of rbin and rempty.
      rbin     <= rbinnext;
      rptr     <= rgraynext;
      rempty   <= (rgraynext == rq2_wptr);
      rundflow <= rundflow | (rinc & rempty);
`ifdef RPTR_EMPTY_LEVEL_EN
      rlevel   <= level_next;
      raempty  <= (level_next <= (ADDRSIZE + 1)'(AEMPTY_THRESH));
`endif
    end
  end

endmodule

// File: tb/tb_rptr_empty.sv
// Directed bench for rptr_empty (ADDRSIZE=5, AEMPTY_THRESH=4); level expectations follow RPTR_EMPTY_LEVEL_EN.
module tb_rptr_empty;

`ifdef RPTR_EMPTY_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic       rclk = 1'b0;
  logic       rrst;
  logic       rinc;
  logic [5:0] rq2_wptr;
  logic       rempty;
  logic [4:0] raddr;
  logic [5:0] rptr;
  logic       rundflow;
  logic [5:0] rlevel;
  logic       raempty;

  int n_vec = 0;
  int n_err = 0;

  rptr_empty #(.ADDRSIZE(5), .AEMPTY_THRESH(4)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rinc     (rinc),
    .rq2_wptr (rq2_wptr),
    .rempty   (rempty),
    .raddr    (raddr),
    .rptr     (rptr),
    .rundflow (rundflow),
    .rlevel   (rlevel),
    .raempty  (raempty)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic       rinc;
    logic [5:0] wptr;
    logic       e_empty;
    logic [4:0] e_raddr;
    logic [5:0] e_rptr;
    logic       e_und;
    int         e_lvl;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_lvl(input int l);
    return LVL ? 32'(l) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_ae(input int l);
    return LVL ? 32'(l <= 4) : 32'd1;
  endfunction

  task automatic tick();
    @(negedge rclk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_empty, input logic [4:0] e_raddr,
                           input logic [5:0] e_rptr, input logic e_und, input int e_lvl);
    check({tag, ".rempty"},   32'(rempty),   32'(e_empty));
    check({tag, ".raddr"},    32'(raddr),    32'(e_raddr));
    check({tag, ".rptr"},     32'(rptr),     32'(e_rptr));
    check({tag, ".rundflow"}, 32'(rundflow), 32'(e_und));
    check({tag, ".rlevel"},   32'(rlevel),   exp_lvl(e_lvl));
    check({tag, ".raempty"},  32'(raempty),  exp_ae(e_lvl));
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    #1;
    rrst = 1'b0;
  endtask

  initial begin
    // Starting from reset, rbin=0. Gray codes: 1=000001 2=000011 3=000010 4=000110
    // 5=000111 6=000101 7=000100 8=001100.
    vt[0]  = '{1'b0, 6'b000001, 1'b0, 5'd0, 6'b000000, 1'b0, 1}; // write ptr 1 -> not empty
    vt[1]  = '{1'b1, 6'b000001, 1'b1, 5'd1, 6'b000001, 1'b0, 0}; // read it -> empty
    vt[2]  = '{1'b0, 6'b000101, 1'b0, 5'd1, 6'b000001, 1'b0, 5}; // wptr 6 -> level 5
    vt[3]  = '{1'b1, 6'b000101, 1'b0, 5'd2, 6'b000011, 1'b0, 4}; // threshold reached
    vt[4]  = '{1'b1, 6'b000101, 1'b0, 5'd3, 6'b000010, 1'b0, 3};
    vt[5]  = '{1'b1, 6'b000101, 1'b0, 5'd4, 6'b000110, 1'b0, 2};
    vt[6]  = '{1'b1, 6'b000101, 1'b0, 5'd5, 6'b000111, 1'b0, 1};
    vt[7]  = '{1'b1, 6'b000101, 1'b1, 5'd6, 6'b000101, 1'b0, 0}; // drained
    vt[8]  = '{1'b1, 6'b000101, 1'b1, 5'd6, 6'b000101, 1'b1, 0}; // underflow, pointer holds
    vt[9]  = '{1'b1, 6'b000101, 1'b1, 5'd6, 6'b000101, 1'b1, 0};
    vt[10] = '{1'b1, 6'b000101, 1'b1, 5'd6, 6'b000101, 1'b1, 0};
    vt[11] = '{1'b0, 6'b000101, 1'b1, 5'd6, 6'b000101, 1'b1, 0}; // sticky after rinc drops
    vt[12] = '{1'b0, 6'b000100, 1'b0, 5'd6, 6'b000101, 1'b1, 1}; // wptr 7 -> empty drops next edge
    vt[13] = '{1'b1, 6'b001100, 1'b0, 5'd7, 6'b000100, 1'b1, 1}; // read and write on same edge
    vt[14] = '{1'b1, 6'b001100, 1'b1, 5'd8, 6'b001100, 1'b1, 0};

    // Asynchronous reset with the clock not yet having produced a falling edge.
    rrst = 1'b1;
    rinc = 1'b0;
    rq2_wptr = 6'b000000;
    #2;
    check_all("reset", 1'b1, 5'd0, 6'b000000, 1'b0, 0);
    rrst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      rinc     = vt[i].rinc;
      rq2_wptr = vt[i].wptr;
      tick();
      check_all($sformatf("vec%0d", i), vt[i].e_empty, vt[i].e_raddr, vt[i].e_rptr,
                vt[i].e_und, vt[i].e_lvl);
    end

    // Full FIFO: write pointer one lap ahead (gray 32 = 110000), then 32 reads wrap raddr.
    do_reset();
    rinc = 1'b0;
    rq2_wptr = 6'b110000;
    tick();
    check_all("full", 1'b0, 5'd0, 6'b000000, 1'b0, 32);
    rinc = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("wrap%0d.raddr", i),  32'(raddr),  32'((i + 1) % 32));
      check($sformatf("wrap%0d.rempty", i), 32'(rempty), 32'(i == 31));
      check($sformatf("wrap%0d.rlevel", i), 32'(rlevel), exp_lvl(31 - i));
    end
    rinc = 1'b0;
    tick();
    check_all("wrapped", 1'b1, 5'd0, 6'b110000, 1'b0, 0);

    // Reset between edges at rbin=10 (wptr gray 12 = 001010, gray 10 = 001111).
    do_reset();
    rq2_wptr = 6'b001010;
    tick();
    rinc = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rinc = 1'b0;
    check_all("pre_rst", 1'b0, 5'd10, 6'b001111, 1'b0, 2);
    #3;
    rrst = 1'b1;
    #1;
    check_all("async_rst", 1'b1, 5'd0, 6'b000000, 1'b0, 0);
    rrst = 1'b0;
    rq2_wptr = 6'b000000;
    tick();
    check_all("post_rst", 1'b1, 5'd0, 6'b000000, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
